seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 22 ++
 rtl/div_status_gen.sv | 20 ++
 rtl/seq_divider.sv | 137 +++++++++++++
 tb/tb_seq_divider.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// ---------------------------------------------------------------------------
// seq_divider_pkg : shared FSM state encoding and status-flag bit positions
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seq_divider_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_DONE = 2'd2;

  localparam int DIV0    = 0;
  localparam int PARITY  = 1;
  localparam int ALLONES = 2;
  localparam int OVF     = 3;

endpackage

`default_nettype wire

// File: rtl/div_status_gen.sv
// ---------------------------------------------------------------------------
// div_status_gen : all-ones and even-nonzero-parity flags of a quotient
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_status_gen #(
  parameter int M = 8
) (
  input  logic [M-1:0] quotient,
  output logic         all_ones,
  output logic         even_parity
);

  assign all_ones    = &quotient;
  assign even_parity = (|quotient) & ~(^quotient);

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider : signed restoring divider, one quotient bit per clock
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int M = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [M-1:0] i_arg_A,
  input  logic [M-1:0] i_arg_B,
  output logic         o_busy,
  output logic         o_valid,
  output logic [M-1:0] o_div,
  output logic [M-1:0] o_rem,
  output logic [3:0]   o_status
);

  localparam int CNT_W = $clog2(M + 1);

  state_t         state;
  logic [CNT_W-1:0] count;
  logic [M-1:0]   quo;
  logic [M-1:0]   dvs;
  logic [M-1:0]   rem;
  logic           neg_q;
  logic           neg_r;
  logic           div0;
  logic           ovf;

  logic [M-1:0]   abs_a;
  logic [M-1:0]   abs_b;
  logic           start_div0;
  logic           start_ovf;
  logic [M:0]     shifted;
  logic [M:0]     diff;
  logic [M-1:0]   final_q;
  logic [M-1:0]   final_r;
  logic           all_ones;
  logic           even_parity;
  logic [3:0]     status;

  // Magnitudes as unsigned: -2^(M-1) maps to 2^(M-1), which still fits in M bits.
  assign abs_a      = i_arg_A[M-1] ? -i_arg_A : i_arg_A;
  assign abs_b      = i_arg_B[M-1] ? -i_arg_B : i_arg_B;
  assign start_div0 = (i_arg_B == '0);
  assign start_ovf  = (i_arg_A == {1'b1, {(M-1){1'b0}}}) && (&i_arg_B);

  assign shifted = {rem, quo[M-1]};
  assign diff    = shifted - {1'b0, dvs};

  assign final_q = (div0 | ovf) ? '0 : (neg_q ? -quo : quo);
  assign final_r = (div0 | ovf) ? '0 : (neg_r ? -rem : rem);

  div_status_gen #(
    .M (M)
  ) u_status (
    .quotient    (final_q),
    .all_ones    (all_ones),
    .even_parity (even_parity)
  );

  always_comb begin
    status          = 4'b0000;
    status[DIV0]    = div0;
    status[OVF]     = ovf;
    status[ALLONES] = all_ones;
    status[PARITY]  = even_parity;
  end

  assign o_busy = (state == S_CALC);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      quo      <= '0;
      dvs      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0     <= 1'b0;
      ovf      <= 1'b0;
      o_valid  <= 1'b0;
      o_div    <= '0;
      o_rem    <= '0;
      o_status <= 4'b0000;
    end else begin
      o_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            div0  <= start_div0;
            ovf   <= start_ovf;
            neg_q <= i_arg_A[M-1] ^ i_arg_B[M-1];
            neg_r <= i_arg_A[M-1];
            quo   <= abs_a;
            dvs   <= abs_b;
            rem   <= '0;
            count <= '0;
            state <= (start_div0 | start_ovf) ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          // Restore when the trial subtraction goes negative.
          if (!diff[M]) begin
            rem <= diff[M-1:0];
            quo <= {quo[M-2:0], 1'b1};
          end else begin
            rem <= shifted[M-1:0];
            quo <= {quo[M-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == CNT_W'(M - 1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          o_div    <= final_q;
          o_rem    <= final_r;
          o_status <= status;
          o_valid  <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider : directed and random checks of seq_divider against an
// integer-arithmetic reference. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider;

  localparam int M = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [M-1:0] arg_a = '0;
  logic [M-1:0] arg_b = '0;
  logic         busy;
  logic         valid;
  logic [M-1:0] div_o;
  logic [M-1:0] rem_o;
  logic [3:0]   status;

  int checks = 0;
  int errors = 0;

  logic [M-1:0] prev_q = '0;
  logic [M-1:0] prev_r = '0;
  logic [3:0]   prev_s = '0;

  always #5 clk = ~clk;

  seq_divider #(.M(M)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_arg_A  (arg_a),
    .i_arg_B  (arg_b),
    .o_busy   (busy),
    .o_valid  (valid),
    .o_div    (div_o),
    .o_rem    (rem_o),
    .o_status (status)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: SystemVerilog integer / and % already truncate toward zero.
  task automatic model(input int a, input int b, output logic [7:0] q, output logic [7:0] r,
                       output logic [3:0] st, output int lat);
    int qi;
    int ri;
    if (b == 0) begin
      q = 8'h00; r = 8'h00; st = 4'b0001; lat = 1;
    end else if (a == -128 && b == -1) begin
      q = 8'h00; r = 8'h00; st = 4'b1000; lat = 1;
    end else begin
      qi = a / b;
      ri = a % b;
      q  = qi[7:0];
      r  = ri[7:0];
      st = 4'b0000;
      st[2] = (q == 8'hFF);
      st[1] = (q != 8'h00) && (($countones(q) % 2) == 0);
      lat = M + 1;
    end
  endtask

  // Called at a negedge; returns at the negedge where o_valid is seen.
  task automatic run_op(input logic signed [7:0] a, input logic signed [7:0] b, input bit disturb);
    logic [7:0] eq;
    logic [7:0] er;
    logic [3:0] es;
    int lat;
    int cyc;
    model(int'(a), int'(b), eq, er, es, lat);
    arg_a = a;
    arg_b = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("pulse_end", {31'd0, valid}, 32'd0);
    check("hold_div", {24'd0, div_o}, {24'd0, prev_q});
    check("hold_rem", {24'd0, rem_o}, {24'd0, prev_r});
    check("hold_status", {28'd0, status}, {28'd0, prev_s});
    check("busy", {31'd0, busy}, (lat > 1) ? 32'd1 : 32'd0);
    cyc = 0;
    while (!valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (disturb && cyc == 3) begin
        start = 1'b1;
        arg_a = 8'($urandom);
        arg_b = 8'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("latency", cyc, lat);
    check("quot", {24'd0, div_o}, {24'd0, eq});
    check("rem", {24'd0, rem_o}, {24'd0, er});
    check("status", {28'd0, status}, {28'd0, es});
    prev_q = eq;
    prev_r = er;
    prev_s = es;
    if (disturb) begin
      repeat (M + 3) begin
        @(negedge clk);
        check("no_extra_valid", {31'd0, valid}, 32'd0);
      end
    end
  endtask

  task automatic reset_mid_calc();
    arg_a = 8'd100;
    arg_b = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_div", {24'd0, div_o}, 32'd0);
    check("rst_rem", {24'd0, rem_o}, 32'd0);
    check("rst_status", {28'd0, status}, 32'd0);
    repeat (M + 3) begin
      @(negedge clk);
      check("rst_no_valid", {31'd0, valid}, 32'd0);
    end
    prev_q = '0;
    prev_r = '0;
    prev_s = '0;
  endtask

  initial begin
    logic signed [7:0] ra;
    logic signed [7:0] rb;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_div", {24'd0, div_o}, 32'd0);
    check("reset_rem", {24'd0, rem_o}, 32'd0);
    check("reset_status", {28'd0, status}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'sd100, 8'sd7, 1'b0);
    run_op(-8'sd100, 8'sd7, 1'b0);
    run_op(8'sd5, 8'sd0, 1'b0);
    run_op(-8'sd128, -8'sd1, 1'b0);
    run_op(-8'sd1, 8'sd1, 1'b0);
    run_op(8'sd3, 8'sd1, 1'b0);
    run_op(8'sd127, -8'sd128, 1'b0);
    run_op(-8'sd128, 8'sd1, 1'b0);
    run_op(8'sd100, 8'sd7, 1'b1);
    reset_mid_calc();
    run_op(-8'sd77, -8'sd5, 1'b0);

    for (int k = 0; k < 200; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (k % 13 == 0) rb = 8'sd0;
      if (k % 29 == 0) begin
        ra = -8'sd128;
        rb = -8'sd1;
      end
      run_op(ra, rb, (k % 50 == 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
